// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared stream word definitions for router ingress logic
// Contents: word widths, the packed stream word type and the address extractor.
package router_pkg;

  localparam int DATA_WIDTH   = 128;
  localparam int NET_WIDTH    = 4;
  localparam int STREAM_WIDTH = DATA_WIDTH + NET_WIDTH;

  // Destination network address sits in the MSBs, payload below it.
  typedef struct packed {
    logic [NET_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0] data;
  } stream_word_t;

  function automatic logic [NET_WIDTH-1:0] word_addr(input stream_word_t w);
    return w.addr;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x STREAM_WIDTH register array, one write port, async read
// Ports:
//   clk      system clock
//   wr_en    write wr_data into entry wr_ptr at the rising edge
//   wr_ptr   write entry index
//   wr_data  word to store
//   rd_ptr   read entry index
//   rd_data  combinational read of entry rd_ptr
module fifo_mem
  import router_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_ptr,
  input  stream_word_t       wr_data,
  input  logic [PTR_W-1:0]   rd_ptr,
  output stream_word_t       rd_data
);

  stream_word_t mem_q [DEPTH];
  stream_word_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr] = wr_data;
    end
  end

  // Contents are meaningless until written and the control logic never
  // exposes an unwritten entry, so the array carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/router_ingress_fifo.sv
// rtl/router_ingress_fifo.sv - credit-flow-controlled FWFT ingress buffer for one router stream
// Optional feature macro: ROUTER_INGRESS_HWM_EN (adds hwm_clr input and hwm output).
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   hwm_clr     (ROUTER_INGRESS_HWM_EN) clear high-water mark to current count
//   hwm         (ROUTER_INGRESS_HWM_EN) high-water mark of occupancy
//   in_valid    link word present this cycle
//   in_stream   link word
//   credit_ret  one-cycle pulse returning one credit to the link
//   out_valid   head word available
//   out_ready   router consumed the head word this cycle
//   out_stream  head word
//   out_addr    head word destination address
//   count       current occupancy 0..DEPTH
//   ovf_err     sticky overflow flag
module router_ingress_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef ROUTER_INGRESS_HWM_EN
  input  logic                    hwm_clr,
  output logic [PTR_W:0]          hwm,
`endif
  input  logic                    in_valid,
  input  logic [STREAM_WIDTH-1:0] in_stream,
  output logic                    credit_ret,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [STREAM_WIDTH-1:0] out_stream,
  output logic [NET_WIDTH-1:0]    out_addr,
  output logic [PTR_W:0]          count,
  output logic                    ovf_err
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             credit_q, credit_d;
  logic             ovf_q, ovf_d;

  logic             full;
  logic             push;
  logic             pop;
  stream_word_t     head_word;

  assign full      = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0);
  // out_ready is only meaningful while a head word is presented.
  assign pop       = out_valid && out_ready;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign push      = in_valid && (!full || pop);

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    credit_d = pop;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
    // Link sent a word without a credit: word dropped, flag latched.
    if (in_valid && !push) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (wr_ptr_q),
    .wr_data (stream_word_t'(in_stream)),
    .rd_ptr  (rd_ptr_q),
    .rd_data (head_word)
  );

  assign out_stream = head_word;
  assign out_addr   = word_addr(head_word);
  assign count      = count_q;
  assign credit_ret = credit_q;
  assign ovf_err    = ovf_q;

`ifdef ROUTER_INGRESS_HWM_EN
  logic [PTR_W:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr) begin
      hwm_d = count_q;
    end else if (count_d > hwm_q) begin
      hwm_d = count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: doc/router_ingress_fifo.md
Name: router_ingress_fifo

Overview:
- Per-port ingress buffer placed directly upstream of a router in_stream lane (node or core router). One instance per stream.
- Accepts stream words (net address in the top net_width bits, payload below) from a link under credit-based flow control.
- Buffers the words and presents the head word first-word-fall-through with valid/ready to the router's accessor-tree input.
- Returns one credit per word drained, so the link can never overrun the buffer.

Parameters:
- DATA_WIDTH, 128, payload bits per word
- NET_WIDTH, 4, destination network address bits carried in the word MSBs
- STREAM_WIDTH, DATA_WIDTH+NET_WIDTH, total word width
- DEPTH, 4, buffer entries; power of two, minimum 2
- PTR_W, log2(DEPTH), pointer width

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  link word present this cycle
- in_stream  input  STREAM_WIDTH  link word
- credit_ret  output  1  one-cycle pulse, one credit returned to the link
- out_valid  output  1  head word available to the router
- out_ready  input  1  router consumed the head word this cycle
- out_stream  output  STREAM_WIDTH  head word
- out_addr  output  NET_WIDTH  head word destination, out_stream[STREAM_WIDTH-1 -: NET_WIDTH]
- count  output  PTR_W+1  current occupancy, 0..DEPTH
- ovf_err  output  1  sticky overflow flag

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-low (rst_n). All state updates on the clk rising edge.
- Reset values:
  - count=0, rd_ptr=wr_ptr=0, out_valid=0, credit_ret=0, ovf_err=0.
  - out_stream and out_addr are don't-care while out_valid=0. The bench must not check them then.
- Credit contract: after reset the link owns DEPTH credits. Each in_valid consumes one credit. Each credit_ret pulse returns one.
- push = in_valid && (count<DEPTH || pop).
- pop = out_valid && out_ready. out_ready is ignored while out_valid=0.
- Latency: a word pushed at edge N appears on out_stream with out_valid=1 after edge N; it can be consumed in cycle N+1. There is no same-cycle bypass from empty.
- Counter updates:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged. This applies when full, so a full buffer pushed and popped in the same cycle accepts the word.
  - Pointers wrap modulo DEPTH.
- credit_ret is registered: it is 1 in the cycle after each pop, exactly one pulse per popped word. Back-to-back pops give back-to-back pulses.
- Overflow: in_valid while count==DEPTH and no pop means the word is dropped. State is unchanged, no credit is returned, and ovf_err sets and holds until reset.
- Ordering: strict FIFO. out_stream always equals the oldest unpopped word.
- Reset mid-operation: all contents are discarded and all outputs take their reset values on the next edge. A credit_ret pending from a pop in the reset cycle is suppressed. The link must re-initialise its credits to DEPTH.

Optional Feature:
- Macro ROUTER_INGRESS_HWM_EN.
- Defined:
  - Adds output port hwm [PTR_W:0], a high-water mark of count.
  - hwm resets to 0 and updates to max(hwm, next count) every cycle.
  - Adds input hwm_clr: a synchronous clear to the current count that takes priority over the max update.
- Undefined: neither port exists and there is no logic. All other behaviour is identical.

Decomposition:
- Shared package router_pkg holds:
  - the localparams DATA_WIDTH, NET_WIDTH, STREAM_WIDTH;
  - the stream word typedef as a packed struct {addr[NET_WIDTH], data[DATA_WIDTH]};
  - a function for extracting the address.
- Natural sub-module: fifo_mem, a DEPTH x STREAM_WIDTH register array with one write port and an asynchronous read port.
- The pointer/count/credit control stays in router_ingress_fifo.

Test Plan:
- Reset then push 0xA|{128'h1}, out_ready=0. Expected: out_valid=1 one cycle later, out_addr=4'hA, count=1, credit_ret stays 0.
- Fill 4 words with out_ready=0, then a 5th in_valid. Expected: count=4, 5th word dropped, ovf_err=1 and sticky, head is still word 0.
- Full, then in_valid and out_ready in the same cycle. Expected: count stays 4, word 0 leaves, new word at the tail, one credit_ret pulse next cycle, ovf_err stays 0.
- Stream 10 words with in_valid=out_ready=1 continuously after the first. Expected: output order 0..9, pointer wrap is correct, 10 credit_ret pulses total, count ends 0.
- Assert rst_n=0 with 3 words held and a pop in the same cycle. Expected: next cycle count=0, out_valid=0, credit_ret=0.
- With ROUTER_INGRESS_HWM_EN: push 3, pop 3. Expected: hwm=3. Then hwm_clr. Expected: hwm=0.
